unified_mem_arb: RTL and testbench
==================================

// Module: unified_mem_arb
// PURPOSE
//  Single-ported unified instruction/data memory with a two-requester arbiter and a req/ack handshake.
//  Replaces the separate zero-latency imemory/dmemory pair so that multicycle and pipelined cores can
//  stall on memory. Adds configurable wait states, byte/half/word access with sign/zero extension,
//  and misalignment detection. Sits between the core's fetch/LSU ports and storage in the top level.
// PARAMETERS
//  XLEN          32    data/address width (bits)
//  DEPTH_WORDS   1024  storage depth in XLEN-bit words (power of 2)
//  WAIT_STATES   1     extra cycles per access, 0..7
//  DATA_PRIORITY 1     1: data port always wins a conflict; 0: round-robin between the two ports
//  INIT_FILE     ""    hex image loaded with $readmemh at time 0 when non-empty
// PORTS
//  clk         in   1     clock, rising edge
//  reset       in   1     asynchronous, active-high reset
//  i_req       in   1     instruction fetch request (word read)
//  i_addr      in   XLEN  fetch byte address
//  i_ack       out  1     one-cycle pulse: i_rdata valid
//  i_rdata     out  XLEN  fetched word
//  d_req       in   1     data request
//  d_we        in   1     1 = store, 0 = load
//  d_size      in   2     00 byte, 01 half, 10 word (11 treated as word)
//  d_unsigned  in   1     loads: 1 zero-extend, 0 sign-extend
//  d_addr      in   XLEN  data byte address
//  d_wdata     in   XLEN  store data, right-aligned (low byte/half used)
//  d_ack       out  1     one-cycle pulse: access complete, d_rdata valid for loads
//  d_rdata     out  XLEN  extended load data (0 for stores and errors)
//  d_err       out  1     pulses with d_ack when the access was misaligned
// BEHAVIOUR
//  - Reset (async): FSM->IDLE, wait counter 0, rr pointer -> data, i_ack/d_ack/d_err 0, i_rdata/d_rdata 0.
//    Memory contents are NOT cleared. A write in flight when reset asserts is discarded.
//  - FSM: IDLE -> (any req) BUSY if WAIT_STATES>0, else RESP; BUSY counts WAIT_STATES down and enters
//    RESP at the edge where the count is 0; RESP -> IDLE unconditionally.
//  - The grant, address, size, we and wdata are captured at the IDLE edge. Later changes to the req
//    inputs are ignored until the next IDLE.
//  - The ack of the granted port is high only in RESP. First ack cycle = WAIT_STATES+1 cycles after req
//    is sampled. Throughput = one access per WAIT_STATES+2 cycles.
//  - Requester holds req (stable) until ack. Dropping req early is a protocol violation; the access
//    still completes.
//  - Store commits to memory at the edge entering RESP. Load/fetch data is registered at the same edge
//    and held until the next RESP.
//  - Arbitration, both req high in IDLE:
//    - DATA_PRIORITY=1: data wins.
//    - DATA_PRIORITY=0: the port not granted last conflict wins; the first conflict after reset goes
//      to data. The rr pointer updates only on conflicts.
//    - The losing req stays pending and is granted at the next IDLE.
//  - Index = addr[$clog2(DEPTH_WORDS)+1:2]; upper address bits are ignored (aliasing/wrap, no error).
//  - Fetch: always word; i_addr[1:0] ignored.
//  - Misaligned data access (half with addr[0]=1; word with addr[1:0]!=0):
//    - no memory write; d_rdata=0;
//    - d_err=1 with d_ack; same latency as a normal access.
//  - Stores write only the byte lanes selected by d_size/addr[1:0]; data is replicated onto the lanes.
//  - Loads: byte lane addr[1:0] / half lane addr[1], then extend per d_unsigned.
// TESTING
//  - WAIT_STATES=2, word store 0xDEADBEEF @0x40, then word load @0x40 -> each d_ack 3 cycles after
//    req; d_rdata=0xDEADBEEF; RESP->IDLE gap of 1 cycle.
//  - Byte store 0x80 @0x41, lb @0x41 -> 0xFFFFFF80; lbu -> 0x00000080; lw @0x40 -> 0xDEAD80EF.
//  - DATA_PRIORITY=0, i_req and d_req held high together -> grants alternate D,I,D,I, no starvation;
//    DATA_PRIORITY=1 -> D granted first, I next.
//  - lw @0x42 and sh @0x43 -> d_ack with d_err=1, d_rdata=0; subsequent lw @0x40 shows memory unchanged.
//  - Reset asserted mid-BUSY of store 0x12345678 @0x80 -> acks 0 immediately; after release, lw @0x80
//    returns the prior contents.
//  - DEPTH_WORDS=1024, store to 0x1000 then load 0x0000 -> same word (wrap alias).

Source files
------------

// File: rtl/unified_mem_arb.sv
// ============================================================================
// Module : unified_mem_arb
// Brief  : Single-ported unified I/D memory, two-port arbiter, req/ack handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module unified_mem_arb #(
    parameter int    XLEN          = 32,
    parameter int    DEPTH_WORDS   = 1024,
    parameter int    WAIT_STATES   = 1,
    parameter int    DATA_PRIORITY = 1,
    parameter string INIT_FILE     = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [1:0]      d_size,
    input  logic            d_unsigned,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err
);

    localparam int          c_AW      = $clog2(DEPTH_WORDS);
    localparam int          c_NB      = XLEN / 8;
    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_BUSY    = 2'd1;
    localparam logic [1:0]  c_RESP    = 2'd2;
    localparam logic [2:0]  c_WS_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [c_NB-1:0] c_BE_B = 1;
    localparam logic [c_NB-1:0] c_BE_H = 3;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic [1:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            rr_q;
    logic            gnt_d_q;
    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic            we_q;
    logic            uns_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] i_rdata_q;
    logic [XLEN-1:0] d_rdata_q;

    logic            w_any_req;
    logic            w_pick_data;
    logic            w_idle;
    logic            w_capture;
    logic            w_enter_resp;
    logic            w_gnt_data;
    logic [XLEN-1:0] w_addr;
    logic [1:0]      w_size;
    logic            w_we;
    logic            w_uns;
    logic [XLEN-1:0] w_wdata;
    logic [c_AW-1:0] w_idx;
    logic            w_mis;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_load;
    logic [c_NB-1:0] w_be;
    logic [XLEN-1:0] w_wrep;
    logic            w_unused_bits;

    // rr_q = 1 means data wins the next conflict
    assign w_any_req   = i_req | d_req;
    assign w_pick_data = d_req & (~i_req | (DATA_PRIORITY != 0) | rr_q);
    assign w_idle      = (state_q == c_IDLE);
    assign w_capture   = w_idle & w_any_req;

    // In IDLE the live request drives the datapath so a zero-wait access can complete at once
    always_comb begin
        if (w_idle) begin
            w_gnt_data = w_pick_data;
            w_addr     = w_pick_data ? d_addr : i_addr;
            w_size     = w_pick_data ? d_size : 2'b10;
            w_we       = w_pick_data & d_we;
            w_uns      = d_unsigned;
            w_wdata    = d_wdata;
        end else begin
            w_gnt_data = gnt_d_q;
            w_addr     = addr_q;
            w_size     = size_q;
            w_we       = we_q;
            w_uns      = uns_q;
            w_wdata    = wdata_q;
        end
    end

    assign w_idx         = w_addr[c_AW+1:2];
    assign w_unused_bits = ^w_addr[XLEN-1:c_AW+2];
    assign w_mis         = w_gnt_data & (((w_size == 2'b01) & w_addr[0]) |
                                         (w_size[1] & (w_addr[1:0] != 2'b00)));
    assign w_word        = mem_q[w_idx];
    assign w_shift       = w_word >> {w_addr[1:0], 3'b000};

    always_comb begin
        case (w_size)
            2'b00:   w_load = {{(XLEN-8){w_shift[7] & ~w_uns}}, w_shift[7:0]};
            2'b01:   w_load = {{(XLEN-16){w_shift[15] & ~w_uns}}, w_shift[15:0]};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        case (w_size)
            2'b00: begin
                w_be   = c_BE_B << w_addr[1:0];
                w_wrep = {c_NB{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = c_BE_H << w_addr[1:0];
                w_wrep = {(c_NB/2){w_wdata[15:0]}};
            end
            default: begin
                w_be   = '1;
                w_wrep = w_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (w_any_req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = c_BUSY;
                        cnt_d   = c_WS_INIT;
                    end else begin
                        state_d = c_RESP;
                    end
                end
            end
            c_BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = c_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            c_RESP:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    assign w_enter_resp = (state_d == c_RESP) && (state_q != c_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= c_IDLE;
            cnt_q     <= 3'd0;
            rr_q      <= 1'b1;
            gnt_d_q   <= 1'b0;
            addr_q    <= '0;
            size_q    <= 2'b00;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_capture) begin
                gnt_d_q <= w_gnt_data;
                addr_q  <= w_addr;
                size_q  <= w_size;
                we_q    <= w_we;
                uns_q   <= w_uns;
                wdata_q <= w_wdata;
                if (i_req & d_req) begin
                    rr_q <= ~w_pick_data;
                end
            end
            if (w_enter_resp) begin
                if (w_gnt_data) begin
                    d_rdata_q <= (w_we | w_mis) ? '0 : w_load;
                end else begin
                    i_rdata_q <= w_word;
                end
            end
        end
    end

    // Reset drops the FSM out of BUSY asynchronously, so an in-flight store never reaches RESP
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_gnt_data && w_we && !w_mis) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        i_ack = 1'b0;
        d_ack = 1'b0;
        d_err = 1'b0;
        if (state_q == c_RESP) begin
            if (gnt_d_q) begin
                d_ack = 1'b1;
                d_err = w_mis;
            end else begin
                i_ack = 1'b1;
            end
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arb.sv
// ============================================================================
// Module : tb_unified_mem_arb
// Brief  : Directed vector bench for unified_mem_arb (WS=2 priority, WS=1 round-robin).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_unified_mem_arb;

    logic        clk;
    logic        rst;

    logic        i_req, i_ack, d_req, d_we, d_unsigned, d_ack, d_err;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;

    logic        rr_i_req, rr_i_ack, rr_d_req, rr_d_we, rr_d_unsigned, rr_d_ack, rr_d_err;
    logic [31:0] rr_i_addr, rr_i_rdata, rr_d_addr, rr_d_wdata, rr_d_rdata;
    logic [1:0]  rr_d_size;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    unified_mem_arb #(
        .XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2), .DATA_PRIORITY(1), .INIT_FILE("")
    ) u_dut (
        .clk(clk), .reset(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err)
    );

    unified_mem_arb #(
        .XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(1), .DATA_PRIORITY(0), .INIT_FILE("")
    ) u_rr (
        .clk(clk), .reset(rst),
        .i_req(rr_i_req), .i_addr(rr_i_addr), .i_ack(rr_i_ack), .i_rdata(rr_i_rdata),
        .d_req(rr_d_req), .d_we(rr_d_we), .d_size(rr_d_size), .d_unsigned(rr_d_unsigned),
        .d_addr(rr_d_addr), .d_wdata(rr_d_wdata), .d_ack(rr_d_ack), .d_rdata(rr_d_rdata),
        .d_err(rr_d_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where d_ack is seen
    task automatic d_access(input vec_t v, output logic [31:0] rd, output logic er, output int lat);
        d_we       = v.we;
        d_size     = v.sz;
        d_unsigned = v.uns;
        d_addr     = v.addr;
        d_wdata    = v.wdata;
        d_req      = 1'b1;
        lat        = -1;
        rd         = 'x;
        er         = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_ack) begin
                lat = c;
                rd  = d_rdata;
                er  = d_err;
                break;
            end
        end
        d_req = 1'b0;
    endtask

    task automatic i_fetch(input logic [31:0] a, output logic [31:0] rd, output int lat);
        i_addr = a;
        i_req  = 1'b1;
        lat    = -1;
        rd     = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (i_ack) begin
                lat = c;
                rd  = i_rdata;
                break;
            end
        end
        i_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        vec_t        v;
        logic [1:0]  exp_g;
        logic        seen;

        //            we    sz     uns   addr          wdata         exp_rd        err
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0041, 32'h0000_0080, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0041, 32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0041, 32'h0,         32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0042, 32'h0,         32'hFFFF_DEAD, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0,         32'h0000_DEAD, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0042, 32'h0,         32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0043, 32'h0000_5555, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0042, 32'hFFFF_1234, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_80EF, 1'b0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[15] = '{1'b1, 2'd0, 1'b0, 32'h0000_0003, 32'hAAAA_AA7F, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         32'h7FFE_F00D, 1'b0};
        vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0,         32'h0000_007F, 1'b0};
        vecs[18] = '{1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0,         32'h0000_7FFE, 1'b0};
        vecs[19] = '{1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'h0,         32'hFFFF_FFF0, 1'b0};

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
        rr_i_req = 1'b0; rr_i_addr = '0;
        rr_d_req = 1'b0; rr_d_we = 1'b0; rr_d_size = 2'd2; rr_d_unsigned = 1'b0;
        rr_d_addr = '0; rr_d_wdata = '0;

        repeat (3) @(negedge clk);
        chk("reset_acks", {29'd0, i_ack, d_ack, d_err}, 32'd0);
        chk("reset_i_rdata", i_rdata, 32'd0);
        chk("reset_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            d_access(vecs[i], rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), lat, 32'd3);
            @(negedge clk);
            chk($sformatf("v%0d_gap", i), {31'd0, d_ack}, 32'd0);
        end

        // Fetch ignores i_addr[1:0]; upper bits alias
        i_fetch(32'h0000_0042, rd, lat);
        chk("fetch_42_rdata", rd, 32'h1234_80EF);
        chk("fetch_42_latency", lat, 32'd3);
        @(negedge clk);
        i_fetch(32'h0000_1003, rd, lat);
        chk("fetch_alias_rdata", rd, 32'h7FFE_F00D);
        @(negedge clk);

        // Fixed priority: data granted first, instruction afterwards
        i_addr = 32'h0000_0040; i_req = 1'b1;
        d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h0; d_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) seen = 1'b1;
        end
        chk("prio_first_grant", {30'd0, d_ack, i_ack}, 32'd2);
        chk("prio_d_rdata", d_rdata, 32'h7FFE_F00D);
        d_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) seen = 1'b1;
        end
        chk("prio_second_grant", {30'd0, d_ack, i_ack}, 32'd1);
        chk("prio_i_rdata", i_rdata, 32'h1234_80EF);
        i_req = 1'b0;
        @(negedge clk);

        // Round-robin with both requests held: D, I, D, I
        rr_i_req = 1'b1;
        rr_d_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 2'b10 : 2'b01;
            seen  = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (rr_i_ack || rr_d_ack) seen = 1'b1;
            end
            chk($sformatf("rr_grant%0d", g), {30'd0, rr_d_ack, rr_i_ack}, {30'd0, exp_g});
        end
        rr_i_req = 1'b0;
        rr_d_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a store's wait states discards it
        v = '{1'b1, 2'd2, 1'b0, 32'h0000_0080, 32'h1111_2222, 32'h0, 1'b0};
        d_access(v, rd, er, lat);
        @(negedge clk);
        v = '{1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b0};
        d_access(v, rd, er, lat);
        chk("pre_reset_load", rd, 32'h1111_2222);
        @(negedge clk);
        d_we = 1'b1; d_size = 2'd2; d_addr = 32'h0000_0080; d_wdata = 32'h1234_5678; d_req = 1'b1;
        @(negedge clk);
        chk("busy_no_ack", {31'd0, d_ack}, 32'd0);
        chk("busy_rdata_held", d_rdata, 32'h1111_2222);
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_acks", {29'd0, i_ack, d_ack, d_err}, 32'd0);
        chk("mid_reset_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d_access(v, rd, er, lat);
        chk("post_reset_load", rd, 32'h1111_2222);
        chk("post_reset_latency", lat, 32'd3);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
